// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency/period meter:
//   - fmcState_t : measurement sequencer states
//   - DEF_GATE_W : default width of the gate-window length
//   - DEF_CNT_W  : default width of edge-count and period results
//   - satInc()   : saturating increment used by every result counter
// ---------------------------------------------------------------------------
package freq_meter_pkg;

  localparam int DEF_GATE_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    REPORT
  } fmcState_t;

  // Counters of different widths share this helper by working on a 32-bit
  // copy and passing in their own all-ones ceiling.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input logic [31:0] maxVal);
    return (value >= maxVal) ? maxVal : value + 32'd1;
  endfunction

endpackage

// File: rtl/freq_meter_ctrl_sig_sync_edge.sv
// ---------------------------------------------------------------------------
// sig_sync_edge
// Brings the asynchronous signal under test into the clk domain through a
// two-flop synchronizer, then flags rising edges with one extra delay flop.
// Ports:
//   clk      : sampling clock
//   rst      : synchronous active-high reset, clears all three flops
//   sig_in   : asynchronous input signal
//   edge_det : one-cycle pulse per synchronized rising edge
// The pulse output is called edge_det because "edge" is a reserved word.
// ---------------------------------------------------------------------------
module sig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_det
);

  logic r_sync1;
  logic r_sync2;
  logic r_syncDly;

  // Metastability chain followed by the delay flop used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_syncDly <= 1'b0;
    end else begin
      r_sync1   <= sig_in;
      r_sync2   <= r_sync1;
      r_syncDly <= r_sync2;
    end
  end

  assign edge_det = r_sync2 & ~r_syncDly;

endmodule

// File: rtl/freq_meter_ctrl.sv
// ---------------------------------------------------------------------------
// freq_meter_ctrl
// Runs gated measurement windows on an asynchronous test signal and reports,
// per window, the number of rising edges and the shortest/longest
// edge-to-edge period (in clk cycles) through a valid/ready result port.
//
// Build option: define FMC_JITTER_EN to build min/max period tracking.
// Without it period_min/period_max read 0 and overflow only reflects
// edge-count saturation.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start       : one-cycle measurement request, honoured only in IDLE
//   gate_cycles : window length in clk cycles, captured on accepted start
//   sig_in      : asynchronous signal under test
//   busy        : high while arming, measuring or holding a result
//   res_valid   : result available
//   res_ready   : consumer accepts the result
//   edge_count  : rising edges counted inside the window
//   period_min  : shortest period seen (0 when no edges were counted)
//   period_max  : longest period seen
//   overflow    : a counter saturated during the window (sticky per run)
// ---------------------------------------------------------------------------
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_W = DEF_GATE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              sig_in,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  edge_count,
  output logic [CNT_W-1:0]  period_min,
  output logic [CNT_W-1:0]  period_max,
  output logic              overflow
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  fmcState_t         r_state;
  fmcState_t         w_nextState;
  logic              w_edge;
  logic              w_startAccept;
  logic [GATE_W-1:0] r_gateLen;
  logic [GATE_W-1:0] r_gateCnt;
  logic [CNT_W-1:0]  r_edgeCount;
  logic              r_countOvf;

  sig_sync_edge uSyncEdge (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .edge_det (w_edge)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. ARM gives up once the countdown
  // loaded with the window length has hit zero without a reference edge;
  // MEASURE ends on the cycle the countdown reads 1.
  always_comb begin
    w_nextState   = r_state;
    w_startAccept = 1'b0;
    busy          = 1'b0;
    res_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (gate_cycles != '0)) begin
          w_startAccept = 1'b1;
          w_nextState   = ARM;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (w_edge) begin
          w_nextState = MEASURE;
        end else if (r_gateCnt == '0) begin
          w_nextState = REPORT;
        end
      end
      MEASURE: begin
        busy = 1'b1;
        if (r_gateCnt == GATE_W'(1)) begin
          w_nextState = REPORT;
        end
      end
      REPORT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Window countdown and edge counter. Results are cleared when a start is
  // accepted so a timed-out ARM reports all zeros, and left untouched in
  // REPORT so they stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gateLen   <= '0;
      r_gateCnt   <= '0;
      r_edgeCount <= '0;
      r_countOvf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startAccept) begin
            r_gateLen   <= gate_cycles;
            r_gateCnt   <= gate_cycles;
            r_edgeCount <= '0;
            r_countOvf  <= 1'b0;
          end
        end
        ARM: begin
          if (w_edge) begin
            r_gateCnt <= r_gateLen;
          end else if (r_gateCnt != '0) begin
            r_gateCnt <= r_gateCnt - GATE_W'(1);
          end
        end
        MEASURE: begin
          r_gateCnt <= r_gateCnt - GATE_W'(1);
          if (w_edge) begin
            r_edgeCount <= CNT_W'(satInc(32'(r_edgeCount), CNT_MAX));
            if (32'(r_edgeCount) == CNT_MAX) begin
              r_countOvf <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign edge_count = r_edgeCount;

`ifdef FMC_JITTER_EN
  logic [CNT_W-1:0] r_periodCnt;
  logic [CNT_W-1:0] r_periodMin;
  logic [CNT_W-1:0] r_periodMax;
  logic             r_periodOvf;

  // Period tracking. The reference edge in ARM restarts the period counter
  // at 1, so an edge N cycles later samples exactly N. The minimum starts
  // from all-ones so the first real period always replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_periodCnt <= '0;
      r_periodMin <= '1;
      r_periodMax <= '0;
      r_periodOvf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startAccept) begin
            r_periodMin <= '1;
            r_periodMax <= '0;
            r_periodOvf <= 1'b0;
          end
        end
        ARM: begin
          if (w_edge) begin
            r_periodCnt <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (w_edge) begin
            if (r_periodCnt < r_periodMin) begin
              r_periodMin <= r_periodCnt;
            end
            if (r_periodCnt > r_periodMax) begin
              r_periodMax <= r_periodCnt;
            end
            r_periodCnt <= CNT_W'(1);
          end else begin
            r_periodCnt <= CNT_W'(satInc(32'(r_periodCnt), CNT_MAX));
            if (32'(r_periodCnt) == CNT_MAX) begin
              r_periodOvf <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Hide the all-ones starting value when no period was ever sampled.
  assign period_min = (r_edgeCount == '0) ? '0 : r_periodMin;
  assign period_max = r_periodMax;
  assign overflow   = r_countOvf | r_periodOvf;
`else
  assign period_min = '0;
  assign period_max = '0;
  assign overflow   = r_countOvf;
`endif

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_meter_ctrl
// Directed bench for freq_meter_ctrl. A 16-bit instance covers the main
// scenarios; a CNT_W=4 instance covers edge-count saturation. Expected
// results are queued when a measurement is started and popped when the
// result appears. Period expectations follow FMC_JITTER_EN.
// ---------------------------------------------------------------------------
module tb_freq_meter_ctrl;

`ifdef FMC_JITTER_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif

  typedef struct {
    int edgeCount;
    int pMin;
    int pMax;
    int ovf;
  } expResult_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] gateCycles = '0;
  logic        sigIn = 1'b0;
  logic        resReady = 1'b0;
  logic        useSmall = 1'b0;

  logic        busyB, validB, ovfB;
  logic [15:0] countB, minB, maxB;
  logic        busyS, validS, ovfS;
  logic [3:0]  countS, minS, maxS;

  logic        obsBusy, obsValid, obsOvf;
  logic [15:0] obsCount, obsMin, obsMax;

  expResult_t  scoreboard[$];
  int          checkCount = 0;
  int          passCount = 0;
  int          failCount = 0;

  bit          genOn = 1'b0;
  int          halfA = 10;
  int          halfB = 10;
  int          genCount = 0;
  bit          genSel = 1'b0;

  always #5 clk = ~clk;

  freq_meter_ctrl #(.GATE_W(16), .CNT_W(16)) dutBig (
    .clk(clk), .rst(rst), .start(start & ~useSmall), .gate_cycles(gateCycles),
    .sig_in(sigIn), .busy(busyB), .res_valid(validB),
    .res_ready(resReady & ~useSmall), .edge_count(countB),
    .period_min(minB), .period_max(maxB), .overflow(ovfB)
  );

  freq_meter_ctrl #(.GATE_W(16), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .start(start & useSmall), .gate_cycles(gateCycles),
    .sig_in(sigIn), .busy(busyS), .res_valid(validS),
    .res_ready(resReady & useSmall), .edge_count(countS),
    .period_min(minS), .period_max(maxS), .overflow(ovfS)
  );

  assign obsBusy  = useSmall ? busyS : busyB;
  assign obsValid = useSmall ? validS : validB;
  assign obsOvf   = useSmall ? ovfS : ovfB;
  assign obsCount = useSmall ? 16'(countS) : countB;
  assign obsMin   = useSmall ? 16'(minS) : minB;
  assign obsMax   = useSmall ? 16'(maxS) : maxB;

  // Signal generator: rising-edge periods alternate 2*halfA and 2*halfB,
  // changing shortly after a clk edge to keep sampling deterministic.
  always @(posedge clk) begin
    #2;
    if (!genOn) begin
      sigIn    = 1'b0;
      genCount = 0;
      genSel   = 1'b0;
    end else begin
      genCount++;
      if (genCount >= (genSel ? halfB : halfA)) begin
        genCount = 0;
        if (!sigIn) genSel = !genSel;
        sigIn = !sigIn;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectResult(input int c, input int mn, input int mx, input int ov);
    expResult_t e;
    e.edgeCount = c;
    e.pMin      = JIT ? mn : 0;
    e.pMax      = JIT ? mx : 0;
    e.ovf       = ov;
    scoreboard.push_back(e);
  endtask

  task automatic checkFields(input string tag, input expResult_t e);
    checkOutput({tag, "_count"}, 32'(obsCount), 32'(e.edgeCount));
    checkOutput({tag, "_min"}, 32'(obsMin), 32'(e.pMin));
    checkOutput({tag, "_max"}, 32'(obsMax), 32'(e.pMax));
    checkOutput({tag, "_ovf"}, 32'(obsOvf), 32'(e.ovf));
  endtask

  task automatic applyStimulus(input int gate);
    start      = 1'b1;
    gateCycles = 16'(gate);
    tick(1);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(obsBusy), 32'd1);
  endtask

  task automatic waitResult(input string tag, input int maxCycles,
                            output expResult_t e, output int cycles);
    cycles = 0;
    while (obsValid !== 1'b1 && cycles < maxCycles) begin
      tick(1);
      cycles++;
    end
    checkOutput({tag, "_valid"}, 32'(obsValid), 32'd1);
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
    end else begin
      e = '{-1, -1, -1, -1};
    end
    checkFields(tag, e);
  endtask

  task automatic acceptResult(input string tag);
    resReady = 1'b1;
    tick(1);
    resReady = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(obsValid), 32'd0);
    checkOutput({tag, "_busy_drop"}, 32'(obsBusy), 32'd0);
  endtask

  task automatic setGenerator(input bit on, input int a, input int b);
    genOn = 1'b0;
    tick(6);
    halfA = a;
    halfB = b;
    genOn = on;
  endtask

  initial begin
    expResult_t e;
    int cycles;

    $display("[TB] start");
    tick(4);

    // Reset state.
    checkOutput("rst_busy", 32'(obsBusy), 32'd0);
    checkOutput("rst_valid", 32'(obsValid), 32'd0);
    checkOutput("rst_count", 32'(obsCount), 32'd0);
    checkOutput("rst_min", 32'(obsMin), 32'd0);
    checkOutput("rst_max", 32'(obsMax), 32'd0);
    checkOutput("rst_ovf", 32'(obsOvf), 32'd0);
    rst = 1'b0;
    tick(2);

    // A start with a zero-length window is ignored.
    start      = 1'b1;
    gateCycles = 16'd0;
    tick(1);
    start = 1'b0;
    checkOutput("zero_gate_busy", 32'(obsBusy), 32'd0);

    // Steady clock: period 20, window 200.
    setGenerator(1'b1, 10, 10);
    expectResult(10, 20, 20, 0);
    applyStimulus(200);
    waitResult("steady", 400, e, cycles);
    acceptResult("steady");

    // Jitter: periods alternate 18 and 22, window 400.
    setGenerator(1'b1, 9, 11);
    expectResult(20, 18, 22, 0);
    applyStimulus(400);
    waitResult("jitter", 600, e, cycles);
    acceptResult("jitter");

    // ARM timeout: no edges, window 50 -> result 51 cycles after busy.
    setGenerator(1'b0, 10, 10);
    tick(6);
    expectResult(0, 0, 0, 0);
    applyStimulus(50);
    waitResult("timeout", 200, e, cycles);
    checkOutput("timeout_latency", 32'(cycles), 32'd51);
    acceptResult("timeout");

    // Backpressure: result held for 5 cycles, a start pulse is ignored.
    setGenerator(1'b1, 10, 10);
    expectResult(5, 20, 20, 0);
    applyStimulus(100);
    waitResult("bp", 300, e, cycles);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start      = 1'b1;
        gateCycles = 16'd30;
      end
      tick(1);
      start = 1'b0;
      checkOutput("bp_hold_valid", 32'(obsValid), 32'd1);
      checkFields("bp_hold", e);
    end
    acceptResult("bp");

    // Back-to-back start in the first IDLE cycle after the transfer.
    expectResult(3, 20, 20, 0);
    applyStimulus(60);
    waitResult("b2b", 200, e, cycles);
    acceptResult("b2b");

    // Reset in the middle of MEASURE, then a clean measurement.
    applyStimulus(200);
    tick(55);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(obsBusy), 32'd0);
    checkOutput("midrst_valid", 32'(obsValid), 32'd0);
    checkOutput("midrst_count", 32'(obsCount), 32'd0);
    checkOutput("midrst_min", 32'(obsMin), 32'd0);
    checkOutput("midrst_max", 32'(obsMax), 32'd0);
    checkOutput("midrst_ovf", 32'(obsOvf), 32'd0);
    tick(2);
    expectResult(5, 20, 20, 0);
    applyStimulus(100);
    waitResult("postrst", 300, e, cycles);
    acceptResult("postrst");

    // Saturation on the 4-bit instance: 25 edges of period 4.
    useSmall = 1'b1;
    setGenerator(1'b1, 2, 2);
    expectResult(15, 4, 4, 1);
    applyStimulus(100);
    waitResult("sat", 300, e, cycles);
    acceptResult("sat");

    // Next accepted start clears the sticky overflow.
    setGenerator(1'b0, 2, 2);
    tick(6);
    expectResult(0, 0, 0, 0);
    applyStimulus(20);
    checkOutput("sat_clear_ovf", 32'(obsOvf), 32'd0);
    waitResult("sat_next", 100, e, cycles);
    acceptResult("sat_next");
    useSmall = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
